// File: rtl/ringosc_sweep_ctrl.sv
// Ring-oscillator sweep controller.
// For each clksel value it lets the oscillator settle, counts synchronized
// osc_div rising edges over a fixed gate window, then reports the count.
module ringosc_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int GATE_CYCLES   = 4096,
  parameter int CNT_W         = 16,
  parameter int NUM_SEL       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             osc_div,
  output logic [3:0]       clksel,
  output logic [CNT_W-1:0] meas_count,
  output logic [3:0]       meas_sel,
  output logic             meas_valid,
  output logic             busy,
  output logic             sweep_done
);

  // One phase counter serves both SETTLE and GATE, so size it for the longer.
  localparam int PH_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GATE_LAST   = PH_W'(GATE_CYCLES - 1);
  localparam logic [3:0]       LAST_SEL    = 4'(NUM_SEL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

  state_t           state, state_nxt;
  logic [PH_W-1:0]  ph_cnt, ph_nxt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt, edge_inc;
  logic [3:0]       clksel_nxt;
  logic             meas_load;
  logic             sync1, sync2, hist;
  logic             pulse;

  // osc_div is asynchronous: two-flop synchronizer plus a history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= osc_div;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign pulse    = sync2 & ~hist;
  // Saturating increment; also used to capture an edge in the last gate cycle.
  assign edge_inc = (pulse && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

  // Next-state logic: abort wins over everything, including start.
  always_comb begin
    state_nxt  = state;
    ph_nxt     = ph_cnt;
    edge_nxt   = edge_cnt;
    clksel_nxt = clksel;
    meas_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt  = SETTLE;
          clksel_nxt = 4'd0;
          ph_nxt     = '0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (ph_cnt == SETTLE_LAST) begin
          state_nxt = GATE;
          ph_nxt    = '0;
          edge_nxt  = '0;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      GATE: begin
        edge_nxt = edge_inc;
        if (abort) begin
          state_nxt = IDLE;
        end else if (ph_cnt == GATE_LAST) begin
          state_nxt = REPORT;
          meas_load = 1'b1;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      REPORT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (clksel == LAST_SEL) begin
          if (continuous) begin
            state_nxt  = SETTLE;
            clksel_nxt = 4'd0;
            ph_nxt     = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt  = SETTLE;
          clksel_nxt = clksel + 4'd1;
          ph_nxt     = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the measurement result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      edge_cnt   <= '0;
      clksel     <= 4'd0;
      meas_count <= '0;
      meas_sel   <= 4'd0;
    end else begin
      state    <= state_nxt;
      ph_cnt   <= ph_nxt;
      edge_cnt <= edge_nxt;
      clksel   <= clksel_nxt;
      if (meas_load) begin
        meas_count <= edge_inc;
        meas_sel   <= clksel;
      end
    end
  end

  // Status strobes decode straight from the registered state.
  always_comb begin
    busy       = (state != IDLE);
    meas_valid = (state == REPORT);
    sweep_done = (state == REPORT) && (clksel == LAST_SEL);
  end

endmodule

// File: tb/tb_ringosc_sweep_ctrl.sv
// Randomized bench for ringosc_sweep_ctrl against a schedule-based model.
module tb_ringosc_sweep_ctrl;

  localparam int S    = 4;
  localparam int G    = 16;
  localparam int CW   = 3;
  localparam int NSEL = 3;
  localparam int P    = S + G + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, reset_n, start, continuous, abort, osc_div;
  logic [3:0]    clksel, meas_sel;
  logic [CW-1:0] meas_count;
  logic          meas_valid, busy, sweep_done;

  ringosc_sweep_ctrl #(
    .SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(CW), .NUM_SEL(NSEL)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .abort(abort), .osc_div(osc_div), .clksel(clksel), .meas_count(meas_count),
    .meas_sel(meas_sel), .meas_valid(meas_valid), .busy(busy), .sweep_done(sweep_done)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 0;
  int mode = 0;
  int ph = 0;
  int t;

  // model state
  bit osc_log [0:16383];
  int n = 2;
  bit m_act = 0;
  int m_base = 0;
  int m_clksel = 0;
  int m_cnt = 0;
  int m_msel = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Rising edges seen through the synchronizer in the gate cycles that
  // follow edges g..g+G-1; a rise at edge m shows as a pulse two edges later.
  function automatic int gate_count(input int g);
    int c = 0;
    for (int m = g; m < g + G; m++)
      if (osc_log[m-1] && !osc_log[m-2]) c++;
    return (c > CMAX) ? CMAX : c;
  endfunction

  // Oscillator stimulus: period 4, period 2, random bits, sparse toggles.
  always @(negedge clk) begin
    ph++;
    case (mode)
      0:       osc_div = ph[1];
      1:       osc_div = ph[0];
      2:       osc_div = 1'($urandom % 2);
      default: if ($urandom % 3 == 0) osc_div = ~osc_div;
    endcase
  end

  // Model: a sweep is a fixed schedule of P-cycle slots counted from the
  // start edge; only the slot offset and index matter.
  always @(posedge clk or negedge reset_n) begin : model
    int p, off, slot, sel;
    if (!reset_n) begin
      m_act = 0; m_clksel = 0; m_cnt = 0; m_msel = 0;
    end else begin
      osc_log[n] = osc_div;
      if (!m_act) begin
        if (start && !abort) begin
          m_act = 1;
          m_base = n;
        end
      end else begin
        p = n - 1 - m_base;
        off = p % P;
        slot = p / P;
        sel = slot % NSEL;
        if (abort) m_act = 0;
        else if (off == S + G - 1) begin
          m_cnt = gate_count(m_base + slot * P + S);
          m_msel = sel;
        end else if (off == S + G && sel == NSEL - 1 && !continuous) m_act = 0;
      end
      if (m_act) m_clksel = ((n - m_base) / P) % NSEL;
      n++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : mon
    int p, off, sel, ev, ed;
    if (mon_en) begin
      ev = 0; ed = 0;
      if (m_act) begin
        p = n - 1 - m_base;
        off = p % P;
        sel = (p / P) % NSEL;
        ev = (off == S + G) ? 1 : 0;
        ed = (ev == 1 && sel == NSEL - 1) ? 1 : 0;
      end
      chk("busy", busy, m_act);
      chk("meas_valid", meas_valid, ev);
      chk("sweep_done", sweep_done, ed);
      chk("clksel", clksel, m_clksel);
      chk("meas_count", meas_count, m_cnt);
      chk("meas_sel", meas_sel, m_msel);
    end
  end

  // Wait for the next report; pulses start while busy to show it is ignored.
  task automatic wait_vld(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);
    end while (!meas_valid && cyc < 200);
    start = 0;
    if (!meas_valid) chk("vld_timeout", meas_valid, 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clksel"}, clksel, 0);
    chk({tag, "_cnt"}, meas_count, 0);
    chk({tag, "_sel"}, meas_sel, 0);
    chk({tag, "_vld"}, meas_valid, 0);
    chk({tag, "_done"}, sweep_done, 0);
  endtask

  initial begin
    clk = 0; reset_n = 1; start = 0; abort = 0; continuous = 0; osc_div = 0;
    #1 reset_n = 0;
    mon_en = 1;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset_n = 1;
    repeat (2) @(negedge clk);

    // full sweep, osc period 4 -> 4 edges per window
    mode = 0;
    start = 1;
    for (int s = 0; s < NSEL; s++) begin
      wait_vld(t);
      chk("lat", t, S + G + 1);
      chk("cnt_p4", meas_count, 4);
      chk("sel_p4", meas_sel, s);
      chk("done_p4", sweep_done, (s == NSEL - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk("idle_after", busy, 0);

    // start together with abort in IDLE is dropped
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    @(negedge clk);
    chk("start_abort", busy, 0);

    // osc period 2 -> 8 edges, saturates at 7; then abort in gate of sel 1
    mode = 1;
    start = 1;
    wait_vld(t);
    chk("sat", meas_count, CMAX);
    repeat (S + 5) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_sel", clksel, 1);
    chk("abort_keep", meas_count, CMAX);
    chk("abort_vld", meas_valid, 0);

    // continuous sweep wraps back to selection 0
    mode = 2;
    continuous = 1;
    start = 1;
    for (int s = 0; s < NSEL; s++) wait_vld(t);
    @(negedge clk);
    chk("cont_clksel", clksel, 0);
    chk("cont_busy", busy, 1);
    wait_vld(t);
    chk("cont_again", meas_sel, 0);
    continuous = 0;
    wait_idle();

    // asynchronous reset in the middle of a gate window
    mode = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (S + 5) @(negedge clk);
    #2 reset_n = 0;
    #1 chk_zero("midrst");
    @(negedge clk);
    reset_n = 1;
    start = 1;
    wait_vld(t);
    chk("rst_lat", t, S + G + 1);
    chk("rst_sel0", meas_sel, 0);
    chk("rst_cnt", meas_count, 4);
    wait_idle();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 250 == 0) mode = $urandom_range(0, 3);
      start = ($urandom % 6 == 0);
      abort = ($urandom % 40 == 0);
      continuous = 1'($urandom % 2);
      if ($urandom % 700 == 0) begin
        #2 reset_n = 0;
        @(negedge clk);
        reset_n = 1;
      end
    end
    @(negedge clk);
    start = 0; abort = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
